sysid_reader: RTL and testbench
===============================

// Module: sysid_reader
// PURPOSE
//  Avalon-MM read master that interrogates a system-ID slave on demand: reads ID word
//  (address 0), then timestamp word (address 1), compares each against build-time
//  expected values, reports match/timeout status. Sits beside the Nios/QSYS fabric,
//  driven by a start strobe from board control logic, status visible on LEDs/debug.
// PARAMETERS
//  EXPECTED_ID        32'd0           value required at address 0 for id_match
//  EXPECTED_TIMESTAMP 32'd1416191880  value required at address 1 for ts_match
//  READ_LATENCY       0               cycles from read acceptance to valid readdata (0..7)
//  TIMEOUT_CYCLES     255             max waitrequest-stall cycles per read; 0 = no timeout
// PORTS
//  clock           in   1   system clock, all logic rising-edge
//  reset_n         in   1   synchronous active-low reset
//  start           in   1   one-cycle request to run a check sequence
//  avm_address     out  1   word address to sysid slave (0=ID, 1=timestamp)
//  avm_read        out  1   read request, registered
//  avm_waitrequest in   1   slave stall; tie 0 for zero-wait slaves
//  avm_readdata    in   32  read data from slave
//  busy            out  1   sequence in progress
//  done            out  1   one-cycle pulse at sequence end
//  id_value        out  32  captured ID word
//  ts_value        out  32  captured timestamp word
//  id_match        out  1   id_value == EXPECTED_ID
//  ts_match        out  1   ts_value == EXPECTED_TIMESTAMP
//  timeout         out  1   last sequence aborted on stall timeout
// BEHAVIOUR
//  Reset (reset_n low at clock edge): state IDLE; all outputs 0, incl. captured values.
//  States: IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, DONE.
//  IDLE: start=1 -> RD_ID; next cycle avm_read=1, avm_address=0, busy=1.
//  RD_x: accept = avm_read & ~avm_waitrequest. On accept: READ_LATENCY=0 -> capture
//   avm_readdata same cycle, advance; else deassert avm_read, -> LAT_x, load lat_cnt.
//  LAT_x: capture avm_readdata exactly READ_LATENCY cycles after accept cycle, advance.
//  Advance from ID -> RD_TS (avm_read=1, avm_address=1 next cycle; back-to-back with
//   ID accept when READ_LATENCY=0). Advance from TS -> DONE.
//  avm_address/avm_read held stable while avm_waitrequest=1 (Avalon rule).
//  Stall counter: cleared on entry to each RD_x, +1 per cycle with waitrequest high;
//   reaching TIMEOUT_CYCLES -> DONE with timeout=1, id_match=ts_match=0, avm_read=0.
//  DONE: lasts one cycle, done=1, busy=0, then IDLE. Matches/values/timeout updated at
//   DONE entry, held until next sequence start.
//  Match flags compare full 32 bits, registered; new start clears timeout, match flags.
//  start while busy or in DONE: ignored (no queuing).
//  Zero-wait, READ_LATENCY=0: start@c0 -> read addr0 c1, read addr1 c2, done c3.
//  reset_n low mid-sequence: immediate IDLE next edge, avm_read drops, no done pulse.
//  avm_read never asserted in IDLE/LAT_x/DONE; at most one outstanding read.
// TESTING
//  T1 zero-wait slave ID=0, TS=1416191880, lat 0; start -> done@c3, id_match=ts_match=1.
//  T2 slave TS=32'h12345678 -> done, id_match=1, ts_match=0, ts_value=32'h12345678.
//  T3 waitrequest high 5 cycles on addr0 -> address/read held stable, done@c8, matches=1.
//  T4 TIMEOUT_CYCLES=4, waitrequest stuck 1 -> done 5 cycles after read, timeout=1, read=0.
//  T5 READ_LATENCY=2, data valid 2 cycles after accept only -> correct capture, done@c7.
//  T6 reset_n low during LAT_TS -> next cycle all outputs 0, no done; restart passes.

Source files
------------

// File: rtl/sysid_reader.sv
// Avalon-MM read master that fetches the system-ID word (address 0) and the timestamp
// word (address 1), compares them against build-time values and reports match/timeout.
module sysid_reader #(
   parameter logic [31:0] EXPECTED_ID        = 32'd0,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1416191880,
   parameter int unsigned READ_LATENCY       = 0,
   parameter int unsigned TIMEOUT_CYCLES     = 255
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] id_value,
   output logic [31:0] ts_value,
   output logic        id_match,
   output logic        ts_match,
   output logic        timeout
);

   typedef enum logic [2:0] {
      S_IDLE, S_RD_ID, S_LAT_ID, S_RD_TS, S_LAT_TS, S_DONE
   } state_t;

   localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT_CYCLES);
   localparam logic [2:0]  LAT_LOAD    = 3'((READ_LATENCY == 0) ? 0 : READ_LATENCY - 1);

   state_t      state_q, state_d;
   logic [15:0] stall_q, stall_d;
   logic [2:0]  lat_q, lat_d;
   logic [31:0] id_cap_q, id_cap_d, ts_cap_q, ts_cap_d;
   logic [31:0] id_value_q, id_value_d, ts_value_q, ts_value_d;
   logic        id_match_q, id_match_d, ts_match_q, ts_match_d;
   logic        timeout_q, timeout_d;
   logic        avm_read_q, avm_read_d, avm_address_q, avm_address_d;
   logic        busy_q, busy_d, done_q, done_d;
   logic        accept;

   assign accept = avm_read_q & ~avm_waitrequest;

   // NOTE: every variable gets its hold value first so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      stall_d    = stall_q;
      lat_d      = lat_q;
      id_cap_d   = id_cap_q;
      ts_cap_d   = ts_cap_q;
      id_value_d = id_value_q;
      ts_value_d = ts_value_q;
      id_match_d = id_match_q;
      ts_match_d = ts_match_q;
      timeout_d  = timeout_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_RD_ID;
               stall_d    = '0;
               id_cap_d   = '0;
               ts_cap_d   = '0;
               id_match_d = 1'b0;
               ts_match_d = 1'b0;
               timeout_d  = 1'b0;
            end
         end
         S_RD_ID, S_RD_TS: begin
            if (accept) begin
               if (READ_LATENCY == 0) begin
                  if (state_q == S_RD_ID) begin
                     id_cap_d = avm_readdata;
                     state_d  = S_RD_TS;
                     stall_d  = '0;
                  end else begin
                     ts_cap_d = avm_readdata;
                     state_d  = S_DONE;
                  end
               end else begin
                  lat_d   = LAT_LOAD;
                  state_d = (state_q == S_RD_ID) ? S_LAT_ID : S_LAT_TS;
               end
            end else if (avm_waitrequest) begin
               // The stall that would push past TIMEOUT_CYCLES aborts the sequence.
               if (TIMEOUT_CYCLES != 0 && stall_q == TIMEOUT_VAL) begin
                  state_d   = S_DONE;
                  timeout_d = 1'b1;
               end else begin
                  stall_d = stall_q + 16'd1;
               end
            end
         end
         S_LAT_ID: begin
            if (lat_q == '0) begin
               id_cap_d = avm_readdata;
               state_d  = S_RD_TS;
               stall_d  = '0;
            end else begin
               lat_d = lat_q - 3'd1;
            end
         end
         S_LAT_TS: begin
            if (lat_q == '0) begin
               ts_cap_d = avm_readdata;
               state_d  = S_DONE;
            end else begin
               lat_d = lat_q - 3'd1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Reported status changes only as the sequence ends.
      if (state_q != S_DONE && state_d == S_DONE) begin
         id_value_d = id_cap_d;
         ts_value_d = ts_cap_d;
         id_match_d = ~timeout_d & (id_cap_d == EXPECTED_ID);
         ts_match_d = ~timeout_d & (ts_cap_d == EXPECTED_TIMESTAMP);
      end

      avm_read_d    = (state_d == S_RD_ID) || (state_d == S_RD_TS);
      avm_address_d = (state_d == S_RD_TS);
      busy_d        = (state_d != S_IDLE) && (state_d != S_DONE);
      done_d        = (state_d == S_DONE);
   end

   // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         stall_q       <= '0;
         lat_q         <= '0;
         id_cap_q      <= '0;
         ts_cap_q      <= '0;
         id_value_q    <= '0;
         ts_value_q    <= '0;
         id_match_q    <= 1'b0;
         ts_match_q    <= 1'b0;
         timeout_q     <= 1'b0;
         avm_read_q    <= 1'b0;
         avm_address_q <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         stall_q       <= stall_d;
         lat_q         <= lat_d;
         id_cap_q      <= id_cap_d;
         ts_cap_q      <= ts_cap_d;
         id_value_q    <= id_value_d;
         ts_value_q    <= ts_value_d;
         id_match_q    <= id_match_d;
         ts_match_q    <= ts_match_d;
         timeout_q     <= timeout_d;
         avm_read_q    <= avm_read_d;
         avm_address_q <= avm_address_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   assign avm_read    = avm_read_q;
   assign avm_address = avm_address_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign id_value    = id_value_q;
   assign ts_value    = ts_value_q;
   assign id_match    = id_match_q;
   assign ts_match    = ts_match_q;
   assign timeout     = timeout_q;

endmodule

// File: tb/tb_sysid_reader.sv
// Bench for sysid_reader: three instances (zero latency, latency 2, short timeout) each
// served by a stalling/latency slave model; results checked against a sequence-level model.
module tb_sysid_reader;

   localparam int          N      = 3;
   localparam logic [31:0] EXP_ID = 32'd0;
   localparam logic [31:0] EXP_TS = 32'd1416191880;

   typedef struct {
      int          inst;
      int          done_cyc;
      logic [31:0] id_v;
      logic [31:0] ts_v;
      logic        id_m;
      logic        ts_m;
      logic        to;
   } exp_t;

   exp_t sb_q[$];

   logic        clock = 1'b0;
   logic        reset_n;
   logic        start_s [N];
   logic        addr_s  [N];
   logic        rd_s    [N];
   logic        wait_s  [N];
   logic [31:0] rdata_s [N];
   logic        busy_s  [N];
   logic        done_s  [N];
   logic [31:0] idv_s   [N];
   logic [31:0] tsv_s   [N];
   logic        idm_s   [N];
   logic        tsm_s   [N];
   logic        to_s    [N];

   // slave model state
   logic [31:0] mem_id [N];
   logic [31:0] mem_ts [N];
   int          plan_id [N];
   int          plan_ts [N];
   int          pend_k [N];
   logic [31:0] pend_word [N];
   logic        in_read [N];
   logic        in_addr [N];
   int          stall_left [N];
   logic        last_wait [N];

   int vectors    = 0;
   int miscompares = 0;
   int cyc        = 0;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   sysid_reader #(.READ_LATENCY(0), .TIMEOUT_CYCLES(255)) u_dut0 (
      .clock(clock), .reset_n(reset_n), .start(start_s[0]),
      .avm_address(addr_s[0]), .avm_read(rd_s[0]), .avm_waitrequest(wait_s[0]),
      .avm_readdata(rdata_s[0]), .busy(busy_s[0]), .done(done_s[0]),
      .id_value(idv_s[0]), .ts_value(tsv_s[0]), .id_match(idm_s[0]),
      .ts_match(tsm_s[0]), .timeout(to_s[0]));

   sysid_reader #(.READ_LATENCY(2), .TIMEOUT_CYCLES(255)) u_dut1 (
      .clock(clock), .reset_n(reset_n), .start(start_s[1]),
      .avm_address(addr_s[1]), .avm_read(rd_s[1]), .avm_waitrequest(wait_s[1]),
      .avm_readdata(rdata_s[1]), .busy(busy_s[1]), .done(done_s[1]),
      .id_value(idv_s[1]), .ts_value(tsv_s[1]), .id_match(idm_s[1]),
      .ts_match(tsm_s[1]), .timeout(to_s[1]));

   sysid_reader #(.READ_LATENCY(0), .TIMEOUT_CYCLES(4)) u_dut2 (
      .clock(clock), .reset_n(reset_n), .start(start_s[2]),
      .avm_address(addr_s[2]), .avm_read(rd_s[2]), .avm_waitrequest(wait_s[2]),
      .avm_readdata(rdata_s[2]), .busy(busy_s[2]), .done(done_s[2]),
      .id_value(idv_s[2]), .ts_value(tsv_s[2]), .id_match(idm_s[2]),
      .ts_match(tsm_s[2]), .timeout(to_s[2]));

   function automatic int lat_of(int g);
      return (g == 1) ? 2 : 0;
   endfunction

   function automatic int to_of(int g);
      return (g == 2) ? 4 : 255;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   // Sequence-level model: each read costs its stall cycles, one accept cycle and the
   // read latency; a read stalled longer than the timeout ends the sequence after
   // TIMEOUT+1 cycles in that read.
   function automatic exp_t model(int g, int c0, logic [31:0] idw, logic [31:0] tsw,
                                  int sid, int sts);
      exp_t e;
      int   tmo = to_of(g);
      int   l   = lat_of(g);
      int   t   = 1;
      e.inst = g;
      e.id_v = '0;
      e.ts_v = '0;
      e.to   = 1'b0;
      if (tmo != 0 && sid > tmo) begin
         e.to = 1'b1;
         t += tmo + 1;
      end else begin
         t += sid + 1 + l;
         e.id_v = idw;
         if (tmo != 0 && sts > tmo) begin
            e.to = 1'b1;
            t += tmo + 1;
         end else begin
            t += sts + 1 + l;
            e.ts_v = tsw;
         end
      end
      e.done_cyc = c0 + t;
      e.id_m = !e.to && (idw == EXP_ID);
      e.ts_m = !e.to && (tsw == EXP_TS);
      return e;
   endfunction

   // Avalon slave: stalls per plan, returns data exactly READ_LATENCY cycles after accept.
   always @(negedge clock) begin
      for (int g = 0; g < N; g++) begin
         if (!reset_n) begin
            pend_k[g]    = 0;
            in_read[g]   = 1'b0;
            last_wait[g] = 1'b0;
            wait_s[g]    = 1'b0;
            rdata_s[g]   = $urandom;
         end else begin
            logic w;
            w = 1'b0;
            rdata_s[g] = $urandom;
            if (pend_k[g] > 0) begin
               check($sformatf("no_read_outstanding_%0d", g), 32'(rd_s[g]), 32'd0);
               pend_k[g]--;
               if (pend_k[g] == 0) rdata_s[g] = pend_word[g];
            end else if (rd_s[g]) begin
               if (!in_read[g]) begin
                  in_read[g]    = 1'b1;
                  in_addr[g]    = addr_s[g];
                  stall_left[g] = addr_s[g] ? plan_ts[g] : plan_id[g];
               end else if (last_wait[g]) begin
                  check($sformatf("addr_held_%0d", g), 32'(addr_s[g]), 32'(in_addr[g]));
               end
               if (stall_left[g] > 0) begin
                  w = 1'b1;
                  stall_left[g]--;
               end else begin
                  logic [31:0] word;
                  word = in_addr[g] ? mem_ts[g] : mem_id[g];
                  in_read[g] = 1'b0;
                  if (lat_of(g) == 0) rdata_s[g] = word;
                  else begin
                     pend_k[g]    = lat_of(g);
                     pend_word[g] = word;
                  end
               end
            end else begin
               in_read[g] = 1'b0;
            end
            wait_s[g]    = w;
            last_wait[g] = w;
         end
      end
   end

   // Monitor: pops the scoreboard whenever any instance pulses done.
   always @(negedge clock) begin
      if (reset_n) begin
         for (int g = 0; g < N; g++) begin
            if (done_s[g]) begin
               if (sb_q.size() == 0) begin
                  check($sformatf("unexpected_done_%0d", g), 32'(done_s[g]), 32'd0);
               end else begin
                  exp_t e;
                  e = sb_q.pop_front();
                  check("done_inst",  g,               e.inst);
                  check("done_cycle", cyc,             e.done_cyc);
                  check("id_value",   idv_s[g],        e.id_v);
                  check("ts_value",   tsv_s[g],        e.ts_v);
                  check("id_match",   32'(idm_s[g]),   32'(e.id_m));
                  check("ts_match",   32'(tsm_s[g]),   32'(e.ts_m));
                  check("timeout",    32'(to_s[g]),    32'(e.to));
                  check("busy_at_done", 32'(busy_s[g]), 32'd0);
                  check("read_at_done", 32'(rd_s[g]),   32'd0);
               end
            end
         end
         if (sb_q.size() > 0 && cyc > sb_q[0].done_cyc + 2) begin
            check("done_missing", 32'(done_s[sb_q[0].inst]), 32'd1);
            void'(sb_q.pop_front());
         end
      end
   end

   task automatic check_zero(int g, string tag);
      check({tag, "_read"},  32'(rd_s[g]),   32'd0);
      check({tag, "_addr"},  32'(addr_s[g]), 32'd0);
      check({tag, "_busy"},  32'(busy_s[g]), 32'd0);
      check({tag, "_done"},  32'(done_s[g]), 32'd0);
      check({tag, "_idv"},   idv_s[g],       32'd0);
      check({tag, "_tsv"},   tsv_s[g],       32'd0);
      check({tag, "_flags"}, {29'd0, idm_s[g], tsm_s[g], to_s[g]}, 32'd0);
   endtask

   task automatic run_seq(int g, logic [31:0] idw, logic [31:0] tsw, int sid, int sts);
      exp_t e;
      mem_id[g]  = idw;
      mem_ts[g]  = tsw;
      plan_id[g] = sid;
      plan_ts[g] = sts;
      @(negedge clock);
      e = model(g, cyc, idw, tsw, sid, sts);
      sb_q.push_back(e);
      start_s[g] = 1'b1;
      @(negedge clock);
      start_s[g] = 1'b0;
      check("busy_c1", 32'(busy_s[g]), 32'd1);
      check("read_c1", {30'd0, rd_s[g], addr_s[g]}, 32'd2);
      // extra start pulses while the sequence runs must be ignored
      for (int k = 0; k < 3000 && sb_q.size() > 0; k++) begin
         @(negedge clock);
         start_s[g] = (cyc <= e.done_cyc) && ($urandom_range(0, 3) == 0);
      end
      start_s[g] = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clock);
   endtask

   function automatic logic [31:0] pick(logic [31:0] good);
      return ($urandom_range(0, 1) == 1) ? good : $urandom;
   endfunction

   initial begin
      reset_n = 1'b0;
      for (int g = 0; g < N; g++) begin
         start_s[g] = 1'b0;
         plan_id[g] = 0;
         plan_ts[g] = 0;
         mem_id[g]  = EXP_ID;
         mem_ts[g]  = EXP_TS;
      end
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      for (int g = 0; g < N; g++) check_zero(g, $sformatf("reset%0d", g));

      run_seq(0, EXP_ID, EXP_TS, 0, 0);              // done at c3
      run_seq(0, EXP_ID, 32'h1234_5678, 0, 0);       // ts mismatch
      run_seq(0, EXP_ID, EXP_TS, 5, 0);              // done at c8
      run_seq(2, EXP_ID, EXP_TS, 1000, 0);           // stuck: timeout
      run_seq(2, EXP_ID, EXP_TS, 4, 4);              // exactly at the limit
      run_seq(1, EXP_ID, EXP_TS, 0, 0);              // done at c7

      // reset while instance 1 sits in its timestamp latency wait
      begin
         int c0;
         mem_id[1]  = EXP_ID;
         mem_ts[1]  = EXP_TS;
         plan_id[1] = 0;
         plan_ts[1] = 0;
         @(negedge clock);
         c0 = cyc;
         start_s[1] = 1'b1;
         @(negedge clock);
         start_s[1] = 1'b0;
         for (int k = 0; k < 20 && cyc < c0 + 5; k++) @(negedge clock);
         reset_n = 1'b0;
         @(negedge clock);
         check_zero(1, "mid_reset");
         reset_n = 1'b1;
         repeat (6) @(negedge clock);
      end
      run_seq(1, EXP_ID, EXP_TS, 0, 0);

      for (int i = 0; i < 20; i++) begin
         run_seq(0, pick(EXP_ID), pick(EXP_TS), $urandom_range(0, 3), $urandom_range(0, 3));
         run_seq(1, pick(EXP_ID), pick(EXP_TS), $urandom_range(0, 3), $urandom_range(0, 3));
         run_seq(2, pick(EXP_ID), pick(EXP_TS), $urandom_range(0, 6), $urandom_range(0, 6));
      end

      repeat (5) @(negedge clock);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
